// File: rtl/key_sender.sv
// key_sender: host-to-lock key transmitter; strobes a..d one at a time, pulses enter,
// then waits for the lock's response and reports it to the host.
module key_sender #(
    parameter int GAP          = 2,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] code,
    input  logic       abort,
    input  logic       lock,
    input  logic       alarm,
    output logic       ip_en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       enter,
    output logic       ready,
    output logic       done,
    output logic [1:0] status
);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_GAP, S_ENTER, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      code_q, code_d;
    logic [3:0]      lines_q, lines_d;
    logic [1:0]      status_q, status_d;
    logic [3:0]      key_bits;

    // The line being strobed shows its bit combinationally in its strobe cycle.
    assign key_bits = (state_q == S_KEY) ? (code_q & (4'b1000 >> step_q)) : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            gcnt_q   <= '0;
            tcnt_q   <= '0;
            code_q   <= '0;
            lines_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            gcnt_q   <= gcnt_d;
            tcnt_q   <= tcnt_d;
            code_q   <= code_d;
            lines_q  <= lines_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        gcnt_d   = gcnt_q;
        tcnt_d   = tcnt_q;
        code_d   = code_q;
        lines_d  = lines_q | key_bits;
        status_d = status_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_KEY;
                step_d   = 2'd0;
                code_d   = code;
                status_d = 2'b00;
            end
            S_KEY: begin
                state_d = S_GAP;
                gcnt_d  = '0;
            end
            S_GAP: if (gcnt_q == G_LAST) begin
                state_d = (step_q == 2'd3) ? S_ENTER : S_KEY;
                step_d  = step_q + 2'd1;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
            S_ENTER: begin
                state_d = S_WAIT;
                tcnt_d  = '0;
            end
            S_WAIT: if (alarm) begin
                state_d  = S_DONE;
                status_d = 2'b11;
            end else if (!lock) begin
                state_d  = S_DONE;
                status_d = 2'b01;
            end else if (tcnt_q == T_LAST) begin
                state_d  = S_DONE;
                status_d = 2'b10;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                lines_d = 4'b0000;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any same-cycle response or sequencing decision.
        if (abort && state_q inside {S_KEY, S_GAP, S_ENTER, S_WAIT}) begin
            state_d  = S_DONE;
            status_d = 2'b10;
        end
    end

    assign ip_en        = (state_q == S_KEY);
    assign {a, b, c, d} = lines_q | key_bits;
    assign enter        = (state_q == S_ENTER);
    assign ready        = (state_q == S_IDLE);
    assign done         = (state_q == S_DONE);
    assign status       = status_q;
endmodule

// File: tb/tb_key_sender.sv
// tb_key_sender: directed scenarios for key_sender with hand-computed cycle timelines.
module tb_key_sender;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] code = 4'h0;
    logic       abort = 1'b0;
    logic       lock = 1'b1;
    logic       alarm = 1'b0;
    logic       ip_en, a, b, c, d, enter, ready, done;
    logic [1:0] status;

    int nvec = 0;
    int nerr = 0;

    logic       r_ip  [64];
    logic       r_en  [64];
    logic       r_dn  [64];
    logic       r_rdy [64];
    logic [3:0] r_ln  [64];
    logic [1:0] r_st  [64];

    key_sender #(.GAP(2), .RESP_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .code(code), .abort(abort),
        .lock(lock), .alarm(alarm), .ip_en(ip_en), .a(a), .b(b), .c(c), .d(d),
        .enter(enter), .ready(ready), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the accept cycle; inputs change 1ns after posedge, outputs sampled at negedge.
    task automatic run(input int n, input logic [3:0] c0, input int lk, input int al,
                       input int ab, input int s1, input int s2, input logic [3:0] c2,
                       input int rc);
        for (int k = 0; k < n; k++) begin
            start = (k == 0) || (k == s1) || (k == s2);
            code  = (k == 0) ? c0 : (k == s1) ? 4'b0101 : c2;
            lock  = (k != lk);
            alarm = (k == al);
            abort = (k == ab);
            if (k == rc) reset = 1'b0;
            else if (k == rc + 1) reset = 1'b1;
            @(negedge clk);
            r_ip[k]  = ip_en;
            r_en[k]  = enter;
            r_dn[k]  = done;
            r_rdy[k] = ready;
            r_ln[k]  = {a, b, c, d};
            r_st[k]  = status;
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; alarm = 1'b0; lock = 1'b1; reset = 1'b1;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = ready;
            @(posedge clk);
            #1;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL drain: ready got 0 required 1 within 40 cycles");
        end
    endtask

    task automatic test_reset();
        #12;
        nvec++;
        if ({ready, ip_en, a, b, c, d, enter, done, status} !== 10'b1_0000_0000_0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b required 1000000000",
                     {ready, ip_en, a, b, c, d, enter, done, status});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unlock();
        run(18, 4'b1010, 15, -1, -1, -1, -1, 4'h0, -1);
        for (int k = 0; k < 18; k++) begin
            nvec++;
            if ({r_ip[k], r_en[k], r_dn[k], r_rdy[k]} !==
                {(k == 1 || k == 4 || k == 7 || k == 10), k == 13, k == 16, (k == 0 || k == 17)}) begin
                nerr++;
                $display("FAIL unlock_ctrl c=%0d: ip/en/done/rdy got %b%b%b%b",
                         k, r_ip[k], r_en[k], r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if ({r_ln[1], r_ln[4], r_ln[7], r_ln[10], r_ln[16], r_ln[17]} !== 24'h88AAA0) begin
            nerr++;
            $display("FAIL unlock_lines: got %h %h %h %h %h %h required 8 8 a a a 0",
                     r_ln[1], r_ln[4], r_ln[7], r_ln[10], r_ln[16], r_ln[17]);
        end
        nvec++;
        if ({r_st[15], r_st[16], r_st[17]} !== 6'b00_01_01) begin
            nerr++;
            $display("FAIL unlock_status: got %b %b %b required 00 01 01", r_st[15], r_st[16], r_st[17]);
        end
        drain();
    endtask

    task automatic test_timeout();
        run(24, 4'b1010, -1, -1, -1, -1, -1, 4'h0, -1);
        for (int k = 13; k < 24; k++) begin
            nvec++;
            if ({r_en[k], r_dn[k], r_rdy[k]} !== {k == 13, k == 22, k == 23}) begin
                nerr++;
                $display("FAIL timeout_ctrl c=%0d: en/done/rdy got %b%b%b", k, r_en[k], r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if ({r_st[21], r_st[22]} !== 4'b00_10) begin
            nerr++;
            $display("FAIL timeout_status: got %b %b required 00 10", r_st[21], r_st[22]);
        end
        drain();
    endtask

    task automatic test_alarm_priority();
        run(17, 4'b1010, 14, 14, -1, -1, -1, 4'h0, -1);
        for (int k = 13; k < 17; k++) begin
            nvec++;
            if ({r_dn[k], r_rdy[k]} !== {k == 15, k == 16}) begin
                nerr++;
                $display("FAIL alarm_ctrl c=%0d: done/rdy got %b%b", k, r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if (r_st[15] !== 2'b11) begin
            nerr++;
            $display("FAIL alarm_status: got %b required 11", r_st[15]);
        end
        drain();
    endtask

    task automatic test_abort();
        run(10, 4'b1010, -1, -1, 5, -1, -1, 4'h0, -1);
        for (int k = 0; k < 10; k++) begin
            nvec++;
            if ({r_ip[k], r_en[k], r_dn[k], r_rdy[k]} !==
                {(k == 1 || k == 4), 1'b0, k == 6, (k == 0 || k >= 7)}) begin
                nerr++;
                $display("FAIL abort_ctrl c=%0d: ip/en/done/rdy got %b%b%b%b",
                         k, r_ip[k], r_en[k], r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if ({r_st[6], r_ln[5], r_ln[7], r_ln[9]} !== 14'b10_1000_0000_0000) begin
            nerr++;
            $display("FAIL abort_status_lines: got st=%b ln5=%h ln7=%h ln9=%h required 10 8 0 0",
                     r_st[6], r_ln[5], r_ln[7], r_ln[9]);
        end
    endtask

    task automatic test_back_to_back();
        run(31, 4'b1010, 15, -1, -1, 3, 17, 4'b0011, -1);
        for (int k = 0; k < 31; k++) begin
            nvec++;
            if ({r_ip[k], r_dn[k], r_rdy[k]} !==
                {(k == 1 || k == 4 || k == 7 || k == 10 || k == 18 || k == 21 || k == 24 || k == 27),
                 k == 16, (k == 0 || k == 17)}) begin
                nerr++;
                $display("FAIL b2b_ctrl c=%0d: ip/done/rdy got %b%b%b", k, r_ip[k], r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if ({r_ln[10], r_st[16], r_ln[18], r_ln[27], r_en[30]} !== 15'b1010_01_0000_0011_1) begin
            nerr++;
            $display("FAIL b2b_data: got ln10=%h st16=%b ln18=%h ln27=%h en30=%b required a 01 0 3 1",
                     r_ln[10], r_st[16], r_ln[18], r_ln[27], r_en[30]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        run(24, 4'b1010, -1, -1, -1, -1, -1, 4'h0, 8);
        for (int k = 0; k < 24; k++) begin
            nvec++;
            if ({r_dn[k], r_rdy[k]} !== {1'b0, (k == 0 || k >= 8)}) begin
                nerr++;
                $display("FAIL rst_ctrl c=%0d: done/rdy got %b%b", k, r_dn[k], r_rdy[k]);
            end
        end
        nvec++;
        if ({r_ln[7], r_ln[8], r_ip[8], r_st[8]} !== 11'b1010_0000_0_00) begin
            nerr++;
            $display("FAIL rst_lines: got ln7=%h ln8=%h ip8=%b st8=%b required a 0 0 00",
                     r_ln[7], r_ln[8], r_ip[8], r_st[8]);
        end
        run(18, 4'b0110, 15, -1, -1, -1, -1, 4'h0, -1);
        nvec++;
        if ({r_ip[10], r_ln[10], r_en[13], r_dn[16], r_st[16], r_rdy[17]} !== 10'b1_0110_1_1_01_1) begin
            nerr++;
            $display("FAIL rst_rerun: got ip10=%b ln10=%h en13=%b dn16=%b st16=%b rdy17=%b",
                     r_ip[10], r_ln[10], r_en[13], r_dn[16], r_st[16], r_rdy[17]);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_timeout();
        test_alarm_priority();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
